operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Decode-side operand fetch stage that drives both read ports of the 32x32b
//  zero-register regfile and registers operands into the D->X pipeline register.
//  The regfile returns old data when waddr == raddr, so this stage forwards
//  the writeback value itself.
//  A 32-bit pending-write scoreboard tracks in-flight destinations and stalls
//  RAW/WAW hazards. Sits between instruction decode (upstream) and execute (downstream).
// PARAMETERS
//  DATA_W  32  operand / writeback data width
//  ADDR_W  5   register address width (2**ADDR_W registers, reg 0 hardwired zero)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  in_val     in   1       upstream instruction valid
//  in_rdy     out  1       stage accepts instruction this cycle
//  in_ren0    in   1       instruction reads source 0
//  in_ren1    in   1       instruction reads source 1
//  in_rs0     in   ADDR_W  source 0 register
//  in_rs1     in   ADDR_W  source 1 register
//  in_wen     in   1       instruction writes a destination
//  in_rd      in   ADDR_W  destination register
//  rf_raddr0  out  ADDR_W  regfile read address 0 (= in_rs0, combinational)
//  rf_rdata0  in   DATA_W  regfile read data 0
//  rf_raddr1  out  ADDR_W  regfile read address 1 (= in_rs1, combinational)
//  rf_rdata1  in   DATA_W  regfile read data 1
//  wb_wen     in   1       writeback write enable (same signal as regfile wen)
//  wb_waddr   in   ADDR_W  writeback register
//  wb_wdata   in   DATA_W  writeback data
//  out_val    out  1       D->X register holds valid instruction
//  out_rdy    in   1       execute stage accepts out_* this cycle
//  out_op0    out  DATA_W  resolved operand 0
//  out_op1    out  DATA_W  resolved operand 1
//  out_wen    out  1       registered in_wen (forced 0 if in_rd == 0)
//  out_rd     out  ADDR_W  registered in_rd
// BEHAVIOUR
//  - Reset: out_val=0, out_op0=out_op1=0, out_wen=0, out_rd=0, pending=0.
//  - wbhit_x = wb_wen && wb_waddr==in_rsx && in_rsx!=0 (x=0,1); wbclr_r = wb_wen && wb_waddr==r.
//  - Operand x: in_rsx==0 -> 0; else wbhit_x -> wb_wdata; else rf_rdatax.
//    Operand is don't-care when in_renx=0.
//  - RAW hazard: in_renx && in_rsx!=0 && pending[in_rsx] && !wbhit_x.
//  - WAW hazard: in_wen && in_rd!=0 && pending[in_rd] && !wbclr_in_rd.
//  - in_rdy = !hazard && (!out_val || out_rdy); no dependence on in_val.
//  - Issue: in_val && in_rdy. The D->X register loads the operands,
//    out_wen = in_wen && in_rd!=0, and out_rd. out_val=1 next cycle. Latency 1.
//  - out_val && out_rdy && !issue -> out_val=0. out_val && !out_rdy -> all out_* held.
//  - pending_next = (pending & ~clr) | set.
//    clr = onehot(wb_waddr) if wb_wen. set = onehot(in_rd) if issue && out_wen-next.
//    Same-register set and clr in one cycle: set wins (bit stays 1).
//  - pending[0] is always 0. wb to a non-pending register: only the bypass, no state change.
//  - Downstream keeps at most one write in flight per register; WAW stall enforces this.
//  - rst mid-stall: next cycle out_val=0 and pending=0; any in-flight instruction is dropped.
// TESTING
//  - Reset, then in_val=1 rs0=3 rs1=0 rf_rdata0=0x11 -> in_rdy=1;
//    next cycle out_val=1 out_op0=0x11 out_op1=0.
//  - Issue rd=5, then rs0=5 while pending -> in_rdy=0.
//    wb_wen=1 wb_waddr=5 wb_wdata=0xAB, rf_rdata0=0x0 -> issues, out_op0=0xAB, pending[5]=0.
//  - Issue rd=0 with in_wen=1 -> out_wen=0, pending stays 0; next reader of r0 gets 0, no stall.
//  - out_rdy=0 for 3 cycles with a valid output -> out_* held, in_rdy=0.
//    out_rdy=1 -> next instruction loads the same cycle.
//  - pending[7]=1; issue rd=7 while wb clears 7 -> no stall, pending[7]=1 afterwards.
//  - Assert rst with pending=0x0000_00A0 and out_val=1 -> next cycle out_val=0, pending=0.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads both regfile ports, bypasses the writeback value,
// stalls RAW/WAW hazards via a pending-write scoreboard, and registers the D->X stage.
module operand_fetch_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic              in_ren0,
  input  logic              in_ren1,
  input  logic [ADDR_W-1:0] in_rs0,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_rd,
  output logic [ADDR_W-1:0] rf_raddr0,
  input  logic [DATA_W-1:0] rf_rdata0,
  output logic [ADDR_W-1:0] rf_raddr1,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_op0,
  output logic [DATA_W-1:0] out_op1,
  output logic              out_wen,
  output logic [ADDR_W-1:0] out_rd
);

  localparam int NREG = 1 << ADDR_W;

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_next;
  logic [NREG-1:0]   clr;
  logic [NREG-1:0]   set;
  logic              wbhit0, wbhit1, wbclr_rd;
  logic              raw0, raw1, waw, hazard;
  logic              issue, wen_next;
  logic [DATA_W-1:0] op0_p0, op1_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] op0_p1, op1_p1;
  logic              wen_p1;
  logic [ADDR_W-1:0] rd_p1;

  assign rf_raddr0 = in_rs0;
  assign rf_raddr1 = in_rs1;

  // Stage p0: operand resolution, hazard detection, scoreboard update
  always_comb begin
    wbhit0   = wb_wen && (wb_waddr == in_rs0) && (in_rs0 != '0);
    wbhit1   = wb_wen && (wb_waddr == in_rs1) && (in_rs1 != '0);
    wbclr_rd = wb_wen && (wb_waddr == in_rd);

    op0_p0 = (in_rs0 == '0) ? '0 : (wbhit0 ? wb_wdata : rf_rdata0);
    op1_p0 = (in_rs1 == '0) ? '0 : (wbhit1 ? wb_wdata : rf_rdata1);

    raw0   = in_ren0 && (in_rs0 != '0) && pending[in_rs0] && !wbhit0;
    raw1   = in_ren1 && (in_rs1 != '0) && pending[in_rs1] && !wbhit1;
    waw    = in_wen && (in_rd != '0) && pending[in_rd] && !wbclr_rd;
    hazard = raw0 || raw1 || waw;

    in_rdy   = !hazard && (!vld_p1 || out_rdy);
    issue    = in_val && in_rdy;
    wen_next = in_wen && (in_rd != '0);

    clr = wb_wen ? onehot(wb_waddr) : '0;
    set = (issue && wen_next) ? onehot(in_rd) : '0;
    // Set is applied after clear so a same-cycle reissue keeps the bit; r0 never pends.
    pending_next = ((pending & ~clr) | set) & ~onehot('0);
  end

  // Stage p1: D->X pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      vld_p1  <= 1'b0;
      op0_p1  <= '0;
      op1_p1  <= '0;
      wen_p1  <= 1'b0;
      rd_p1   <= '0;
    end else begin
      pending <= pending_next;
      if (issue) begin
        vld_p1 <= 1'b1;
        op0_p1 <= op0_p0;
        op1_p1 <= op1_p0;
        wen_p1 <= wen_next;
        rd_p1  <= in_rd;
      end else if (out_rdy) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_val = vld_p1;
  assign out_op0 = op0_p1;
  assign out_op1 = op1_p1;
  assign out_wen = wen_p1;
  assign out_rd  = rd_p1;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: expected D->X contents are queued at issue
// and compared when the execute side accepts them; stalls and bypass are checked directly.
module tb_operand_fetch_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_val, in_rdy, in_ren0, in_ren1, in_wen;
  logic [ADDR_W-1:0] in_rs0, in_rs1, in_rd;
  logic [ADDR_W-1:0] rf_raddr0, rf_raddr1;
  logic [DATA_W-1:0] rf_rdata0, rf_rdata1;
  logic              wb_wen;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              out_val, out_rdy, out_wen;
  logic [DATA_W-1:0] out_op0, out_op1;
  logic [ADDR_W-1:0] out_rd;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic              ren0;
    logic              ren1;
    logic [DATA_W-1:0] op0;
    logic [DATA_W-1:0] op1;
    logic              wen;
    logic [ADDR_W-1:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;

  operand_fetch_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy),
    .in_ren0(in_ren0), .in_ren1(in_ren1), .in_rs0(in_rs0), .in_rs1(in_rs1),
    .in_wen(in_wen), .in_rd(in_rd),
    .rf_raddr0(rf_raddr0), .rf_rdata0(rf_rdata0),
    .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_op0(out_op0), .out_op1(out_op1), .out_wen(out_wen), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output side: a transfer happens at the next posedge when out_val && out_rdy.
  always @(negedge clk) begin
    if (!rst && out_val && out_rdy) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_out", 32'(out_val), 32'd0);
      end else begin
        got_e = sb.pop_front();
        if (got_e.ren0) chk("out_op0", out_op0, got_e.op0);
        if (got_e.ren1) chk("out_op1", out_op1, got_e.op1);
        chk("out_wen", 32'(out_wen), 32'(got_e.wen));
        chk("out_rd", 32'(out_rd), 32'(got_e.rd));
      end
    end
  end

  // Caller sits just after a posedge; drives one instruction for one cycle.
  task automatic send(input logic ren0, input logic [ADDR_W-1:0] rs0, input logic [DATA_W-1:0] rf0,
                      input logic ren1, input logic [ADDR_W-1:0] rs1, input logic [DATA_W-1:0] rf1,
                      input logic wen, input logic [ADDR_W-1:0] rd,
                      input logic wbw, input logic [ADDR_W-1:0] wba, input logic [DATA_W-1:0] wbd,
                      input logic exp_rdy, input string tag);
    exp_t e;
    in_val = 1'b1; in_ren0 = ren0; in_rs0 = rs0; rf_rdata0 = rf0;
    in_ren1 = ren1; in_rs1 = rs1; rf_rdata1 = rf1;
    in_wen = wen; in_rd = rd;
    wb_wen = wbw; wb_waddr = wba; wb_wdata = wbd;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_rdy), 32'(exp_rdy));
    if (exp_rdy) begin
      e.ren0 = ren0;
      e.ren1 = ren1;
      e.op0  = (rs0 == '0) ? '0 : ((wbw && wba == rs0) ? wbd : rf0);
      e.op1  = (rs1 == '0) ? '0 : ((wbw && wba == rs1) ? wbd : rf1);
      e.wen  = wen && (rd != '0);
      e.rd   = rd;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_val = 1'b0;
    wb_wen = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_val = 0; in_ren0 = 0; in_ren1 = 0; in_rs0 = 0; in_rs1 = 0;
    in_wen = 0; in_rd = 0; rf_rdata0 = 0; rf_rdata1 = 0;
    wb_wen = 0; wb_waddr = 0; wb_wdata = 0; out_rdy = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_val", 32'(out_val), 0);
    chk("rst_op0", out_op0, 0);
    chk("rst_op1", out_op1, 0);
    chk("rst_wen", 32'(out_wen), 0);
    chk("rst_rd", 32'(out_rd), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic read: rs0=3 from regfile, rs1=0 forced zero; latency 1
    send(1, 5'd3, 32'h11, 1, 5'd0, 32'hDEAD, 0, 5'd0, 0, 5'd0, 0, 1, "basic");
    chk("basic_raddr0", 32'(rf_raddr0), 32'd3);
    @(negedge clk);
    chk("basic_lat_val", 32'(out_val), 1);
    chk("basic_lat_op0", out_op0, 32'h11);
    @(posedge clk); #1;

    // RAW on r5, resolved by writeback bypass
    send(1, 5'd1, 32'h22, 0, 5'd0, 0, 1, 5'd5, 0, 5'd0, 0, 1, "wr5");
    send(1, 5'd5, 32'h0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, "raw5");
    send(1, 5'd5, 32'h0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd5, 32'hAB, 1, "byp5");
    send(1, 5'd5, 32'h77, 1, 5'd5, 32'h77, 0, 5'd0, 0, 5'd0, 0, 1, "clr5");

    // Write to r0 never pends
    send(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd0, 0, 5'd0, 0, 1, "wr0");
    send(1, 5'd0, 32'h99, 0, 5'd0, 0, 1, 5'd0, 0, 5'd0, 0, 1, "rd0");

    // Backpressure: output held for 3 cycles, next instruction loads on release
    send(1, 5'd2, 32'h33, 1, 5'd4, 32'h44, 0, 5'd0, 0, 5'd0, 0, 1, "hold_a");
    out_rdy = 1'b0;
    in_val = 1'b1; in_ren0 = 1; in_rs0 = 5'd6; rf_rdata0 = 32'h66;
    in_ren1 = 0; in_wen = 0; in_rd = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rdy", 32'(in_rdy), 0);
      chk("hold_val", 32'(out_val), 1);
      chk("hold_op0", out_op0, 32'h33);
      chk("hold_op1", out_op1, 32'h44);
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    send(1, 5'd6, 32'h66, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1, "hold_b");

    // Same-cycle set and clear on r7: set wins
    send(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd7, 0, 5'd0, 0, 1, "wr7a");
    send(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd7, 0, 5'd0, 0, 0, "waw7");
    send(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd7, 1, 5'd7, 32'h70, 1, "wr7b");
    send(1, 5'd7, 32'h1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, "raw7");
    send(0, 5'd0, 0, 1, 5'd7, 32'h1, 0, 5'd0, 1, 5'd7, 32'h7B, 1, "byp7");

    // Reset with pending = r5|r7 and a valid output
    send(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd5, 0, 5'd0, 0, 1, "pre5");
    send(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd7, 0, 5'd0, 0, 1, "pre7");
    out_rdy = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_val", 32'(out_val), 0);
    @(posedge clk); #1;
    out_rdy = 1'b1;
    send(1, 5'd5, 32'h55, 1, 5'd7, 32'h57, 1, 5'd5, 0, 5'd0, 0, 1, "post_rst");

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
